// File: rtl/mem_wait_tracker_pkg.sv
// Purpose: shared defaults and strobe decode for the outstanding-memory-request tracker.
// Latency: none (constants and a pure function).
// Backpressure: none; consumers gate LSU issue on mem_full_arry.
package mem_wait_tracker_pkg;

    localparam int WF_PER_CU = 40;
    localparam int NUM_WF    = WF_PER_CU;
    localparam int WFID_W    = 6;
    localparam int CNT_W     = 4;
    localparam int WDOG_W    = 10;

    // One bit of the one-hot strobe decode: does this strobe hit wavefront idx?
    // Ids at or above the wavefront count never match any slot, so they fall away.
    function automatic logic wf_hit(input logic vld, input int id, input int idx);
        return vld && (id == idx);
    endfunction

endpackage

// File: rtl/mem_wait_slot.sv
// Purpose: one wavefront's saturating in-flight counter, priority update and optional watchdog (MEM_WAIT_WATCHDOG_EN).
// Latency: wait/full/timeout come from registers (1 cycle); ovf/unf pulses are same-cycle combinational.
// Backpressure: none; an issue at a full counter is dropped and flagged through ovf_pulse.
module mem_wait_slot #(
    parameter int CNT_W  = mem_wait_tracker_pkg::CNT_W,
    parameter int WDOG_W = mem_wait_tracker_pkg::WDOG_W
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic sgpr_dec,
    input  logic vgpr_dec,
    input  logic clr,
    output logic waiting,
    output logic full,
    output logic ovf_pulse,
    output logic unf_pulse,
    output logic wdog_timeout
);
    import mem_wait_tracker_pkg::*;

    // Two extra bits hold both the sign and the one-past-max value.
    localparam int SW = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (CNT_W < 1 || WDOG_W < 2) begin : g_bad_cfg
        $error("mem_wait_slot: CNT_W must be >= 1 and WDOG_W >= 2");
    end

    logic [CNT_W-1:0]    cnt;
    logic signed [SW-1:0] nxt;
    logic                under;
    logic                over;

    // Signed next-count before clamping.
    always_comb begin
        nxt = signed'({2'b00, cnt}) + signed'(SW'(inc))
            - signed'(SW'(sgpr_dec)) - signed'(SW'(vgpr_dec));
    end

    assign under     = nxt[SW-1];
    assign over      = !under && nxt[CNT_W];
    // A clear discards the cycle's other events, including their errors.
    assign ovf_pulse = !clr && over;
    assign unf_pulse = !clr && under;

    // Counter register: clear beats clamping, clamping beats the plain update.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (under) begin
            cnt <= '0;
        end else if (over) begin
            cnt <= CNT_MAX;
        end else begin
            cnt <= nxt[CNT_W-1:0];
        end
    end

    assign waiting = (cnt != '0);
    assign full    = (cnt == CNT_MAX);

`ifdef MEM_WAIT_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog;
    logic [WDOG_W-1:0] wdog_nxt;
    logic              tmo;

    // Watchdog restarts on any forward progress or when idle, saturates otherwise.
    always_comb begin
        wdog_nxt = wdog;
        if (clr || sgpr_dec || vgpr_dec || (cnt == '0)) begin
            wdog_nxt = '0;
        end else if (wdog != '1) begin
            wdog_nxt = wdog + WDOG_W'(1);
        end
    end

    // Watchdog and sticky timeout registers; only clear or reset drop the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
            tmo  <= 1'b0;
        end else begin
            wdog <= wdog_nxt;
            if (clr) begin
                tmo <= 1'b0;
            end else if (wdog_nxt == '1) begin
                tmo <= 1'b1;
            end
        end
    end

    assign wdog_timeout = tmo;
`else
    assign wdog_timeout = 1'b0;
`endif

endmodule

// File: rtl/mem_wait_tracker.sv
// Purpose: per-wavefront outstanding-memory-request tracker (optional watchdog via MEM_WAIT_WATCHDOG_EN).
// Latency: event in cycle N shows on every output in cycle N+1; no input-to-output combinational path.
// Backpressure: none; issue stage must stall a wavefront while its mem_full_arry bit is set.
module mem_wait_tracker #(
    parameter int NUM_WF = mem_wait_tracker_pkg::NUM_WF,
    parameter int WFID_W = mem_wait_tracker_pkg::WFID_W,
    parameter int CNT_W  = mem_wait_tracker_pkg::CNT_W,
    parameter int WDOG_W = mem_wait_tracker_pkg::WDOG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid,
    input  logic [WFID_W-1:0] lsu_wfid,
    input  logic              lsu_sgpr_done,
    input  logic [WFID_W-1:0] lsu_sgpr_done_wfid,
    input  logic              lsu_vgpr_done,
    input  logic [WFID_W-1:0] lsu_vgpr_done_wfid,
    input  logic              wf_clear,
    input  logic [WFID_W-1:0] wf_clear_wfid,
    output logic [NUM_WF-1:0] mem_wait_arry,
    output logic [NUM_WF-1:0] mem_full_arry,
    output logic              err_overflow,
    output logic              err_underflow,
    output logic [NUM_WF-1:0] wdog_timeout_arry
);
    import mem_wait_tracker_pkg::*;

    if ((64'(1) << WFID_W) < 64'(NUM_WF)) begin : g_bad_cfg
        $error("mem_wait_tracker: WFID_W too narrow for NUM_WF");
    end

    logic [NUM_WF-1:0] iss_hit;
    logic [NUM_WF-1:0] sgpr_hit;
    logic [NUM_WF-1:0] vgpr_hit;
    logic [NUM_WF-1:0] clr_hit;
    logic [NUM_WF-1:0] ovf_vec;
    logic [NUM_WF-1:0] unf_vec;

    for (genvar i = 0; i < NUM_WF; i++) begin : g_slot
        assign iss_hit[i]  = wf_hit(lsu_valid,     int'(lsu_wfid),           i);
        assign sgpr_hit[i] = wf_hit(lsu_sgpr_done, int'(lsu_sgpr_done_wfid), i);
        assign vgpr_hit[i] = wf_hit(lsu_vgpr_done, int'(lsu_vgpr_done_wfid), i);
        assign clr_hit[i]  = wf_hit(wf_clear,      int'(wf_clear_wfid),      i);

        mem_wait_slot #(
            .CNT_W  (CNT_W),
            .WDOG_W (WDOG_W)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .inc          (iss_hit[i]),
            .sgpr_dec     (sgpr_hit[i]),
            .vgpr_dec     (vgpr_hit[i]),
            .clr          (clr_hit[i]),
            .waiting      (mem_wait_arry[i]),
            .full         (mem_full_arry[i]),
            .ovf_pulse    (ovf_vec[i]),
            .unf_pulse    (unf_vec[i]),
            .wdog_timeout (wdog_timeout_arry[i])
        );
    end

    // Sticky error flags collect pulses from every slot; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (|ovf_vec) begin
                err_overflow <= 1'b1;
            end
            if (|unf_vec) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wait_tracker.sv
// Purpose: scoreboard bench for mem_wait_tracker with directed and randomized traffic.
// Latency: expected state is queued per driven cycle and checked one edge later.
// Backpressure: n/a.
module tb_mem_wait_tracker;
    localparam int NUM_WF  = 40;
    localparam int WFID_W  = 6;
    localparam int CNT_W   = 4;
    localparam int WDOG_W  = 10;
    localparam int CNT_MAX = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              lsu_valid = 1'b0;
    logic [WFID_W-1:0] lsu_wfid = '0;
    logic              lsu_sgpr_done = 1'b0;
    logic [WFID_W-1:0] lsu_sgpr_done_wfid = '0;
    logic              lsu_vgpr_done = 1'b0;
    logic [WFID_W-1:0] lsu_vgpr_done_wfid = '0;
    logic              wf_clear = 1'b0;
    logic [WFID_W-1:0] wf_clear_wfid = '0;
    logic [NUM_WF-1:0] mem_wait_arry;
    logic [NUM_WF-1:0] mem_full_arry;
    logic              err_overflow;
    logic              err_underflow;
    logic [NUM_WF-1:0] wdog_timeout_arry;

    mem_wait_tracker #(
        .NUM_WF (NUM_WF),
        .WFID_W (WFID_W),
        .CNT_W  (CNT_W),
        .WDOG_W (WDOG_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .lsu_valid          (lsu_valid),
        .lsu_wfid           (lsu_wfid),
        .lsu_sgpr_done      (lsu_sgpr_done),
        .lsu_sgpr_done_wfid (lsu_sgpr_done_wfid),
        .lsu_vgpr_done      (lsu_vgpr_done),
        .lsu_vgpr_done_wfid (lsu_vgpr_done_wfid),
        .wf_clear           (wf_clear),
        .wf_clear_wfid      (wf_clear_wfid),
        .mem_wait_arry      (mem_wait_arry),
        .mem_full_arry      (mem_full_arry),
        .err_overflow       (err_overflow),
        .err_underflow      (err_underflow),
        .wdog_timeout_arry  (wdog_timeout_arry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_WF-1:0] wt;
        logic [NUM_WF-1:0] fl;
        logic              ovf;
        logic              unf;
    } exp_t;

    exp_t sb_q[$];
    int   m_cnt[NUM_WF];
    bit   m_ovf;
    bit   m_unf;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: counts requests per wavefront as plain integers.
    task automatic model(input bit r, input bit iv, input int iw, input bit sv, input int sw,
                         input bit vv, input int vw, input bit cv, input int cw);
        if (r) begin
            foreach (m_cnt[w]) m_cnt[w] = 0;
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        for (int w = 0; w < NUM_WF; w++) begin
            int n;
            int adds;
            int subs;
            if (cv && cw == w) begin
                m_cnt[w] = 0;
                continue;
            end
            adds = (iv && iw == w) ? 1 : 0;
            subs = ((sv && sw == w) ? 1 : 0) + ((vv && vw == w) ? 1 : 0);
            n = m_cnt[w] + adds - subs;
            if (n < 0) begin
                m_cnt[w] = 0;
                m_unf = 1;
            end else if (n > CNT_MAX) begin
                m_cnt[w] = CNT_MAX;
                m_ovf = 1;
            end else begin
                m_cnt[w] = n;
            end
        end
    endtask

    task automatic drive(input bit r, input bit iv, input int iw, input bit sv, input int sw,
                         input bit vv, input int vw, input bit cv, input int cw);
        exp_t e;
        @(negedge clk);
        rst                = r;
        lsu_valid          = iv;
        lsu_wfid           = iw[WFID_W-1:0];
        lsu_sgpr_done      = sv;
        lsu_sgpr_done_wfid = sw[WFID_W-1:0];
        lsu_vgpr_done      = vv;
        lsu_vgpr_done_wfid = vw[WFID_W-1:0];
        wf_clear           = cv;
        wf_clear_wfid      = cw[WFID_W-1:0];
        model(r, iv, iw, sv, sw, vv, vw, cv, cw);
        for (int w = 0; w < NUM_WF; w++) begin
            e.wt[w] = (m_cnt[w] != 0);
            e.fl[w] = (m_cnt[w] == CNT_MAX);
        end
        e.ovf = m_ovf;
        e.unf = m_unf;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic iss(input int w, input int n);
        for (int k = 0; k < n; k++) drive(0, 1, w, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic sret(input int w, input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 1, w, 0, 0, 0, 0);
    endtask

    function automatic int pick();
        int sel;
        int hot[4] = '{0, 1, 2, 39};
        sel = $urandom_range(0, 9);
        if (sel < 7) return hot[$urandom_range(0, 3)];
        return $urandom_range(0, 47);
    endfunction

    // Monitor: the outputs are valid every cycle, so each queued expectation is
    // compared right after the edge that should have produced it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("mem_wait_arry", 64'(mem_wait_arry), 64'(e.wt));
                chk("mem_full_arry", 64'(mem_full_arry), 64'(e.fl));
                chk("err_overflow",  64'(err_overflow),  64'(e.ovf));
                chk("err_underflow", 64'(err_underflow), 64'(e.unf));
`ifndef MEM_WAIT_WATCHDOG_EN
                chk("wdog_timeout_arry", 64'(wdog_timeout_arry), 64'(0));
`endif
            end
        end
    end

    initial begin
        foreach (m_cnt[w]) m_cnt[w] = 0;
        m_ovf = 0;
        m_unf = 0;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5);

        iss(7, 3);
        sret(7, 3);
        idle(1);

        iss(39, 15);
        iss(39, 1);
        drive(0, 0, 0, 0, 0, 1, 39, 0, 0);
        idle(1);

        iss(2, 1);
        drive(0, 0, 0, 1, 2, 1, 2, 0, 0);
        iss(5, 4);
        drive(0, 1, 5, 0, 0, 1, 5, 0, 0);
        idle(1);

        iss(45, 1);
        iss(9, 6);
        drive(0, 1, 9, 0, 0, 0, 0, 1, 9);
        idle(1);

        iss(11, 2);
        drive(1, 1, 11, 0, 0, 0, 0, 0, 0);
        idle(2);

        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 99) < 55, pick(),
                  $urandom_range(0, 99) < 25, pick(),
                  $urandom_range(0, 99) < 25, pick(),
                  $urandom_range(0, 99) < 3,  pick());
        end
        idle(3);

        repeat (2) @(posedge clk);
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
        #2;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
